// File: rtl/sha_work_feeder_pkg.sv
// Shared types for the SHA work feeder: hash state, job descriptor and FSM encoding.
// Also hosts the nonce stepping helper used by the feeder and by result checkers.
package sha_feeder_pkg;

    typedef logic [255:0] HashState;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } feeder_state_e;

    typedef struct packed {
        HashState    midstate;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } JobDescriptor;

    // 33-bit sum so a step past 2^32 is still visible to the limit compare.
    function automatic logic [32:0] nonce_step(input logic [32:0] cnt, input logic [31:0] stride);
        return cnt + {1'b0, stride};
    endfunction

endpackage

// File: rtl/sha_work_feeder_if.sv
// Core input bundle consumed by each SHA pre-pipeline instance.
// One beat per nonce; newblock marks the first beat of a job.
interface coreInputsIfc;
    logic        valid;
    logic        newblock;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    modport writer (output valid, newblock, w1, w2, w3);
    modport reader (input  valid, newblock, w1, w2, w3);
    modport master (output valid, newblock, w1, w2, w3);
    modport slave  (input  valid, newblock, w1, w2, w3);
endinterface

// File: rtl/sha_work_feeder_nonce.sv
// Nonce tracker: 33-bit counter with load/step and a last-beat flag.
// Latency: load/inc take effect next cycle; last is combinational on the held count.
// Backpressure: none, caller gates inc.
module sha_nonce_tracker
    import sha_feeder_pkg::*;
#(
    parameter logic [31:0] NUMPROCESSORS = 32'd1,
    parameter logic [31:0] NONCE_LIMIT   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc,
    output logic [32:0] cnt,
    output logic        last
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= {1'b0, load_val};
        end else if (inc) begin
            cnt <= nonce_step(cnt, NUMPROCESSORS);
        end
    end

    assign last = nonce_step(cnt, NUMPROCESSORS) > {1'b0, NONCE_LIMIT};

endmodule

// File: rtl/sha_work_feeder.sv
// Job feeder: turns one accepted job into a newblock beat plus one valid beat per nonce.
// Latency: accept to first beat 2 cycles; done one cycle after the last beat.
// Backpressure: stall freezes the stream; SHA_WORK_FEEDER_PRELOAD_EN adds a one-job preload slot.
module sha_work_feeder
    import sha_feeder_pkg::*;
#(
    parameter logic [31:0] PROCESSORINDEX = 32'd0,
    parameter logic [31:0] NUMPROCESSORS  = 32'd1,
    parameter logic [31:0] NONCE_LIMIT    = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  HashState     job_midstate,
    input  logic [31:0]  job_w1,
    input  logic [31:0]  job_w2,
    input  logic [31:0]  job_w3,
    input  logic         stall,
    input  logic         abort,
    coreInputsIfc.writer out,
    output HashState     midstate_o,
    output logic         busy,
    output logic         done
);

    feeder_state_e state_q, state_d;
    JobDescriptor  job_q, job_d, incoming;
    logic          accept, beat, is_last, trk_last, trk_load, ready_d, last_q;
    logic [32:0]   nonce_cnt_unused;

`ifdef SHA_WORK_FEEDER_PRELOAD_EN
    JobDescriptor pre_q, pre_d;
    logic         pre_full_q, pre_full_d;
`endif

    assign incoming = '{midstate: job_midstate, w1: job_w1, w2: job_w2, w3: job_w3};

    sha_nonce_tracker #(
        .NUMPROCESSORS (NUMPROCESSORS),
        .NONCE_LIMIT   (NONCE_LIMIT)
    ) u_nonce (
        .clk      (clk),
        .rst      (rst),
        .load     (trk_load),
        .load_val (PROCESSORINDEX),
        .inc      (beat),
        .cnt      (nonce_cnt_unused),
        .last     (trk_last)
    );

    always_comb begin
        accept   = job_valid & job_ready;
        beat     = (state_q != IDLE) & ~stall & ~abort;
        is_last  = beat & trk_last;
        state_d  = state_q;
        job_d    = job_q;
        trk_load = 1'b0;
`ifdef SHA_WORK_FEEDER_PRELOAD_EN
        pre_d      = pre_q;
        pre_full_d = pre_full_q;
`endif
        case (state_q)
            IDLE: begin
                // An abort coinciding with the handshake drops the job.
                if (accept && !abort) begin
                    state_d  = FIRST;
                    job_d    = incoming;
                    trk_load = 1'b1;
                end
            end
            FIRST, RUN: begin
                if (abort) begin
                    state_d = IDLE;
`ifdef SHA_WORK_FEEDER_PRELOAD_EN
                    pre_full_d = 1'b0;
`endif
                end else if (is_last) begin
                    state_d = IDLE;
`ifdef SHA_WORK_FEEDER_PRELOAD_EN
                    if (pre_full_q) begin
                        state_d    = FIRST;
                        job_d      = pre_q;
                        pre_full_d = 1'b0;
                        trk_load   = 1'b1;
                    end else if (accept) begin
                        state_d  = FIRST;
                        job_d    = incoming;
                        trk_load = 1'b1;
                    end
`endif
                end else begin
                    if (beat) begin
                        state_d = RUN;
                    end
`ifdef SHA_WORK_FEEDER_PRELOAD_EN
                    if (accept) begin
                        pre_d      = incoming;
                        pre_full_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef SHA_WORK_FEEDER_PRELOAD_EN
        ready_d = (state_d == IDLE) | ~pre_full_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            job_q   <= '0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
        end
    end

`ifdef SHA_WORK_FEEDER_PRELOAD_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q      <= '0;
            pre_full_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            pre_full_q <= pre_full_d;
        end
    end
`endif

    // Words and midstate only move on a newblock beat so the pipeline sees a stable job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            job_ready    <= 1'b0;
            out.valid    <= 1'b0;
            out.newblock <= 1'b0;
            out.w1       <= '0;
            out.w2       <= '0;
            out.w3       <= '0;
            midstate_o   <= '0;
            busy         <= 1'b0;
            last_q       <= 1'b0;
            done         <= 1'b0;
        end else begin
            job_ready    <= ready_d;
            out.valid    <= beat;
            out.newblock <= beat & (state_q == FIRST);
            if (beat && state_q == FIRST) begin
                out.w1     <= job_q.w1;
                out.w2     <= job_q.w2;
                out.w3     <= job_q.w3;
                midstate_o <= job_q.midstate;
            end
            busy   <= (state_d != IDLE) | beat;
            last_q <= is_last;
            done   <= last_q;
        end
    end

endmodule
